peripheral_irq_controller: RTL and testbench
============================================

// Module: peripheral_irq_controller
// PURPOSE
// - Consumes the 10-bit peripheral_irq vector produced by the Peripherals block
//   ({pwm_irq[3:0], uart_irq[3:0], gpio_irq[1:0]}).
// - Per-source masking, edge/level capture and fixed-priority encoding.
// - Drives one interrupt line to the CPU; software reads and acknowledges it
//   over a Wishbone slave port in the same 24-bit address space.
// PARAMETERS
// - N_IRQ      10      number of interrupt sources (1..31)
// - ADDR_BITS  8       low address bits decoded; upper wb_adr_i bits ignored
// PORTS
// - wb_clk_i        in   1       clock; all logic rising-edge
// - wb_rst_i        in   1       reset, asynchronous, active-high
// - wb_stb_i        in   1       Wishbone strobe
// - wb_cyc_i        in   1       Wishbone cycle
// - wb_we_i         in   1       1 = write
// - wb_sel_i        in   4       byte lane enables
// - wb_data_i       in   32      write data
// - wb_adr_i        in   24      byte address
// - wb_ack_o        out  1       transfer acknowledge
// - wb_stall_o      out  1       tied 0
// - wb_error_o      out  1       unmapped-offset response
// - wb_data_o       out  32      read data
// - peripheral_irq  in   N_IRQ   raw source lines, synchronous to wb_clk_i
// - irq_out         out  1       interrupt request to CPU
// - irq_id          out  5       index of highest-priority active source
// BEHAVIOUR
// - Registers (offset = wb_adr_i[ADDR_BITS-1:0]; bits >= N_IRQ read 0):
//   - 0x00 ENABLE: RW, reset 0.
//   - 0x04 PENDING: R; write-1-to-clear, edge sources only.
//   - 0x08 EDGE: RW, reset 0; 1 = rising-edge capture, 0 = level.
//   - 0x0C RAW: RO; peripheral_irq as sampled.
//   - 0x10 CLAIM: RO; {valid[31], 26'b0, id[4:0]}.
//     - A read with valid=1 clears pending[id] if that source is edge-mode.
//   - Writes to RO registers are ignored and acked with no error.
// - Byte writes: wb_sel_i[k] gates bits 8k+7:8k. Any offset other than the
//   five above -> wb_error_o instead of wb_ack_o; wb_data_o = 0.
// - Bus handshake:
//   - Request accepted when wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_error_o.
//   - ack/error are registered, high exactly one cycle, on the cycle after
//     acceptance; wb_data_o is valid in that same cycle.
//   - Back-to-back requests are spaced by that one ack cycle.
//   - Dropping wb_cyc_i mid-access does not cancel the side effects of an
//     already-accepted access.
// - Capture:
//   - irq_q <= peripheral_irq every cycle.
//   - Edge mode: pending[i] sets on peripheral_irq[i] & ~irq_q[i].
//   - Level mode: pending[i] = irq_q[i] (combinational view); W1C and CLAIM
//     have no effect.
//   - Set and clear of pending[i] in the same cycle: set wins, so the event
//     is never lost.
//   - Changing EDGE 1->0 discards stored edge pending; 0->1 starts empty.
// - Encoding:
//   - active = pending & ENABLE.
//   - irq_id = lowest set index of active; 0 when active == 0.
//   - irq_out = registered |active; 1-cycle latency from pending/ENABLE
//     change to irq_out.
//   - The CLAIM value is the same-cycle (pre-clear) encode of active.
// - Reset (async assert, sync deassert handled at top level):
//   - All registers, irq_q, irq_out, wb_ack_o, wb_error_o and wb_data_o are 0.
//   - An access in flight when reset asserts is dropped with no ack.
// STRUCTURE
// - Shared package/header: register offset constants (IRQC_ENABLE...IRQC_CLAIM)
//   and the CLAIM valid-bit position, reused by firmware headers.
// - One sub-module, irq_priority_encoder #(N_IRQ): active -> {valid, id};
//   purely combinational.
// - Everything else (bus FSM IDLE->RESP->IDLE, registers, capture) is flat.
// TESTING
// - Reset: all outputs 0; read 0x00/0x04/0x08 -> 0 with a single ack,
//   error = 0.
// - Edge: write ENABLE=0x3FF, EDGE=0x3FF; pulse irq bit 5 for 1 cycle ->
//   irq_out=1 next cycle, irq_id=5. Read CLAIM -> 0x8000_0005; irq_out=0
//   one cycle after the ack.
// - Priority: edges on bits 2 and 7 in the same cycle -> CLAIM returns 2,
//   then 7, then 0x0000_0000.
// - Level: EDGE=0, ENABLE bit 0, hold irq[0]=1 -> W1C to 0x04 does not clear
//   it and irq_out stays 1; drop irq[0] -> irq_out=0 after 1 cycle.
// - Collision: W1C of bit 3 on the same cycle as a new edge on bit 3 ->
//   PENDING bit 3 remains 1.
// - Bus: read 0x14 -> error=1, ack=0, data=0. wb_sel_i=4'b0001 write
//   0xFFFF_FFFF to ENABLE -> ENABLE=0x0FF. Reset asserted during RESP -> no
//   ack, registers 0.

Source files
------------

// File: rtl/peripheral_irq_controller_pkg.sv
// peripheral_irq_controller_pkg: register map and bus state shared with firmware headers.
package peripheral_irq_controller_pkg;
    localparam int IRQC_ENABLE = 'h00;
    localparam int IRQC_PENDING = 'h04;
    localparam int IRQC_EDGE = 'h08;
    localparam int IRQC_RAW = 'h0C;
    localparam int IRQC_CLAIM = 'h10;
    localparam int IRQC_CLAIM_VALID = 31;
    typedef enum logic {IDLE, RESP} bus_state_t;
endpackage

// File: rtl/peripheral_irq_controller_priority_encoder.sv
// irq_priority_encoder: lowest set index of active wins; id is 0 when nothing is active.
module irq_priority_encoder #(
    parameter int N_IRQ = 10
) (
    input  logic [N_IRQ-1:0] active,
    output logic             valid,
    output logic [4:0]       id
);
    always_comb begin
        id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (active[i]) id = 5'(i);
    end
    assign valid = |active;
endmodule

// File: rtl/peripheral_irq_controller.sv
// peripheral_irq_controller: masked edge/level interrupt capture with a Wishbone claim interface.
module peripheral_irq_controller
    import peripheral_irq_controller_pkg::*;
#(
    parameter int N_IRQ = 10,
    parameter int ADDR_BITS = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_data_i,
    input  logic [23:0]      wb_adr_i,
    output logic             wb_ack_o,
    output logic             wb_stall_o,
    output logic             wb_error_o,
    output logic [31:0]      wb_data_o,
    input  logic [N_IRQ-1:0] peripheral_irq,
    output logic             irq_out,
    output logic [4:0]       irq_id
);
    bus_state_t state, state_next;
    logic [N_IRQ-1:0] irq_q, enable_r, edge_r, edge_pend, pending, active, set, clr, wm, wd;
    logic [ADDR_BITS-1:0] offset;
    logic [31:0] wmask, rdata, claim;
    logic accept, wr, rd, err_r, valid, mapped;
    logic hit_en, hit_pend, hit_edge, hit_raw, hit_claim;
    logic unused;

    assign unused = &{1'b0, wb_adr_i, wb_data_i};
    assign wb_stall_o = 1'b0;
    assign offset = wb_adr_i[ADDR_BITS-1:0];
    assign hit_en = offset == ADDR_BITS'(IRQC_ENABLE);
    assign hit_pend = offset == ADDR_BITS'(IRQC_PENDING);
    assign hit_edge = offset == ADDR_BITS'(IRQC_EDGE);
    assign hit_raw = offset == ADDR_BITS'(IRQC_RAW);
    assign hit_claim = offset == ADDR_BITS'(IRQC_CLAIM);
    assign mapped = hit_en | hit_pend | hit_edge | hit_raw | hit_claim;
    // ack/error are only high in RESP, so IDLE already implies ~ack & ~error
    assign accept = wb_cyc_i & wb_stb_i & (state == IDLE);
    assign wr = accept & wb_we_i;
    assign rd = accept & ~wb_we_i;
    assign wmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wm = N_IRQ'(wmask);
    assign wd = N_IRQ'(wb_data_i) & wm;

    assign pending = (edge_r & edge_pend) | (~edge_r & irq_q);
    assign active = pending & enable_r;

    irq_priority_encoder #(.N_IRQ(N_IRQ)) u_enc (
        .active(active),
        .valid(valid),
        .id(irq_id)
    );

    assign claim = (32'(valid) << IRQC_CLAIM_VALID) | 32'(irq_id);
    assign rdata = hit_en ? 32'(enable_r) :
                   hit_pend ? 32'(pending) :
                   hit_edge ? 32'(edge_r) :
                   hit_raw ? 32'(irq_q) :
                   hit_claim ? claim : 32'd0;
    assign set = peripheral_irq & ~irq_q & edge_r;
    assign clr = ((wr & hit_pend) ? wd : '0) | ((rd & hit_claim & valid) ? (N_IRQ'(1) << irq_id) : '0);

    // set is ORed after clear so a colliding edge is never lost; edge_r mask drops level-mode state
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_q <= '0;
            enable_r <= '0;
            edge_r <= '0;
            edge_pend <= '0;
            irq_out <= 1'b0;
        end else begin
            irq_q <= peripheral_irq;
            enable_r <= (wr & hit_en) ? ((enable_r & ~wm) | wd) : enable_r;
            edge_r <= (wr & hit_edge) ? ((edge_r & ~wm) | wd) : edge_r;
            edge_pend <= ((edge_pend & ~clr) | set) & edge_r;
            irq_out <= |active;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            err_r <= 1'b0;
            wb_data_o <= '0;
        end else begin
            state <= state_next;
            err_r <= accept ? ~mapped : err_r;
            wb_data_o <= accept ? rdata : wb_data_o;
        end
    end

    always_comb begin
        state_next = (state == IDLE && accept) ? RESP : IDLE;
    end

    always_comb begin
        wb_ack_o = (state == RESP) & ~err_r;
        wb_error_o = (state == RESP) & err_r;
    end
endmodule

// File: tb/tb_peripheral_irq_controller.sv
// tb_peripheral_irq_controller: directed checks of bus handshake, capture modes, priority and reset.
module tb_peripheral_irq_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0] sel = 4'h0;
    logic [31:0] wdat = '0;
    logic [23:0] adr = '0;
    logic ack, stall, err, irq_out;
    logic [31:0] rdat;
    logic [9:0] irq = '0;
    logic [4:0] irq_id;
    int passed = 0;
    int total = 0;
    logic [31:0] d;
    logic a, e, a2;

    always #5 clk = ~clk;

    peripheral_irq_controller dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb_stb_i(stb),
        .wb_cyc_i(cyc),
        .wb_we_i(we),
        .wb_sel_i(sel),
        .wb_data_i(wdat),
        .wb_adr_i(adr),
        .wb_ack_o(ack),
        .wb_stall_o(stall),
        .wb_error_o(err),
        .wb_data_o(rdat),
        .peripheral_irq(irq),
        .irq_out(irq_out),
        .irq_id(irq_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // called at posedge+1; returns at posedge+1 one cycle after the response
    task automatic bus(input logic w, input logic [23:0] ad, input logic [31:0] dat, input logic [3:0] s,
                       output logic [31:0] rd_o, output logic ack_o, output logic err_o, output logic ack2);
        int n;
        cyc = 1'b1; stb = 1'b1; we = w; adr = ad; wdat = dat; sel = s;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(ack | err) && n < 4);
        rd_o = rdat; ack_o = ack; err_o = err;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step(1);
        ack2 = ack | err;
    endtask

    initial begin
        step(2);
        chk("reset_ack", {31'd0, ack}, 0);
        chk("reset_err", {31'd0, err}, 0);
        chk("reset_irq_out", {31'd0, irq_out}, 0);
        chk("reset_data", rdat, 0);
        chk("stall", {31'd0, stall}, 0);
        rst = 1'b0;
        step(1);
        bus(0, 24'h00, 0, 4'hF, d, a, e, a2);
        chk("rd_enable", d, 0); chk("rd_enable_ack", {29'd0, a, e, a2}, 32'b100);
        bus(0, 24'h04, 0, 4'hF, d, a, e, a2);
        chk("rd_pending", d, 0); chk("rd_pending_ack", {29'd0, a, e, a2}, 32'b100);
        bus(0, 24'h08, 0, 4'hF, d, a, e, a2);
        chk("rd_edge", d, 0); chk("rd_edge_ack", {29'd0, a, e, a2}, 32'b100);
        irq = 10'h155;
        step(1);
        bus(0, 24'h0C, 0, 4'hF, d, a, e, a2);
        chk("rd_raw", d, 32'h155);
        irq = '0;
        step(2);
        bus(1, 24'h0C, 32'hFFFF_FFFF, 4'hF, d, a, e, a2);
        chk("wr_raw_ack", {30'd0, a, e}, 32'b10);
        // edge mode, single source
        bus(1, 24'h00, 32'h3FF, 4'hF, d, a, e, a2);
        bus(1, 24'h08, 32'h3FF, 4'hF, d, a, e, a2);
        bus(0, 24'h08, 0, 4'hF, d, a, e, a2);
        chk("rd_edge_3ff", d, 32'h3FF);
        irq = 10'h020;
        step(1);
        irq = '0;
        chk("edge5_irq_out_lat", {31'd0, irq_out}, 0);
        step(1);
        chk("edge5_irq_out", {31'd0, irq_out}, 1);
        chk("edge5_irq_id", {27'd0, irq_id}, 5);
        bus(0, 24'h10, 0, 4'hF, d, a, e, a2);
        chk("claim5", d, 32'h8000_0005);
        chk("claim5_irq_out_during_ack", {31'd0, a}, 1);
        chk("claim5_irq_out_after", {31'd0, irq_out}, 0);
        // priority
        irq = 10'h084;
        step(1);
        irq = '0;
        step(1);
        bus(0, 24'h10, 0, 4'hF, d, a, e, a2);
        chk("claim_pri2", d, 32'h8000_0002);
        bus(0, 24'h10, 0, 4'hF, d, a, e, a2);
        chk("claim_pri7", d, 32'h8000_0007);
        bus(0, 24'h10, 0, 4'hF, d, a, e, a2);
        chk("claim_empty", d, 0);
        // collision: W1C on bit 3 coincides with a fresh rising edge
        irq = 10'h008;
        step(1);
        irq = '0;
        step(1);
        bus(0, 24'h04, 0, 4'hF, d, a, e, a2);
        chk("pend3", d, 32'h008);
        bus(1, 24'h04, 32'h8, 4'hF, d, a, e, a2);
        bus(0, 24'h04, 0, 4'hF, d, a, e, a2);
        chk("w1c3", d, 0);
        irq = 10'h008;
        bus(1, 24'h04, 32'h8, 4'hF, d, a, e, a2);
        irq = '0;
        bus(0, 24'h04, 0, 4'hF, d, a, e, a2);
        chk("collision_pend3", d, 32'h008);
        bus(1, 24'h04, 32'h8, 4'hF, d, a, e, a2);
        // level mode
        bus(1, 24'h08, 32'h0, 4'hF, d, a, e, a2);
        bus(1, 24'h00, 32'h1, 4'hF, d, a, e, a2);
        irq = 10'h001;
        step(2);
        chk("level_irq_out", {31'd0, irq_out}, 1);
        bus(1, 24'h04, 32'h1, 4'hF, d, a, e, a2);
        bus(0, 24'h04, 0, 4'hF, d, a, e, a2);
        chk("level_w1c_pend", d, 32'h001);
        chk("level_w1c_irq_out", {31'd0, irq_out}, 1);
        irq = '0;
        step(1);
        chk("level_drop_lat", {31'd0, irq_out}, 1);
        step(1);
        chk("level_drop", {31'd0, irq_out}, 0);
        // bus errors and byte lanes
        bus(0, 24'h14, 0, 4'hF, d, a, e, a2);
        chk("bad_off_ack_err", {30'd0, a, e}, 32'b01);
        chk("bad_off_data", d, 0);
        bus(1, 24'h00, 32'h0, 4'hF, d, a, e, a2);
        bus(1, 24'h00, 32'hFFFF_FFFF, 4'b0001, d, a, e, a2);
        bus(0, 24'h00, 0, 4'hF, d, a, e, a2);
        chk("byte_lane_enable", d, 32'h0FF);
        bus(1, 24'h00, 32'hFFFF_FFFF, 4'b0010, d, a, e, a2);
        bus(0, 24'hAB_CD00, 0, 4'hF, d, a, e, a2);
        chk("byte_lane1_upper_adr", d, 32'h3FF);
        // reset during RESP
        bus(1, 24'h08, 32'h3FF, 4'hF, d, a, e, a2);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 24'h00; wdat = 32'h0; sel = 4'hF;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_resp_ack_err", {30'd0, ack, err}, 0);
        chk("rst_resp_data", rdat, 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step(1);
        chk("rst_resp_no_ack", {30'd0, ack, err}, 0);
        rst = 1'b0;
        step(1);
        bus(0, 24'h00, 0, 4'hF, d, a, e, a2);
        chk("rst_enable", d, 0);
        bus(0, 24'h08, 0, 4'hF, d, a, e, a2);
        chk("rst_edge", d, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
